// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional performance counters are enabled by defining IFU_PERF_COUNTERS_EN.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W  = 64;
  localparam int unsigned IFU_INSTR_W = 32;
  localparam int unsigned PERF_CNT_W  = 32;

  // Low PC bits must match this for a word-aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_perf_counter.sv
// Saturating event counter; only present when IFU_PERF_COUNTERS_EN is defined.
`ifdef IFU_PERF_COUNTERS_EN
module ifu_perf_counter
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned W = PERF_CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues instruction-memory reads for the current PC and hands words to decode.
// Define IFU_PERF_COUNTERS_EN to add fetch and memory-stall counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = IFU_ADDR_W,
  parameter int unsigned INSTR_W = IFU_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               pc_advance,
  output logic               fault
`ifdef IFU_PERF_COUNTERS_EN
  ,
  output logic [31:0]        perf_fetches,
  output logic [31:0]        perf_stall_cycles
`endif
);

  fetch_state_e state;

  // Fetch sequencer; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
      pc_advance <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pc_advance <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pc[1:0] != ALIGN_MASK) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            mem_addr <= pc;
            mem_req  <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (flush) begin
              state <= S_IDLE;
            end else begin
              ir       <= mem_rdata;
              ir_pc    <= mem_addr;
              ir_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (flush) begin
            state <= S_DROP;
          end
        end
        // Request stays up until memory answers; the answer is thrown away.
        S_DROP: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= S_IDLE;
          end else if (ir_ready) begin
            ir_valid   <= 1'b0;
            pc_advance <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (flush) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = (state == S_HOLD) && ir_valid && ir_ready && !flush;
  assign stall_evt = ((state == S_REQ) || (state == S_DROP)) && !mem_ack;

  ifu_perf_counter #(.W(32)) u_fetch_cnt (
    .clock (clock),
    .reset (reset),
    .en    (fetch_evt),
    .count (perf_fetches)
  );

  ifu_perf_counter #(.W(32)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .en    (stall_evt),
    .count (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected values are hand-computed per cycle.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic [63:0] pc;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir;
  logic [63:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_advance;
  logic        fault;
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .pc_advance (pc_advance),
    .fault      (fault)
`ifdef IFU_PERF_COUNTERS_EN
    ,
    .perf_fetches      (perf_fetches),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; pc = 64'h0; flush = 1'b0; mem_ack = 1'b0;
    mem_rdata = 32'h0; ir_ready = 1'b0;
    tick(); tick();
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_ir", 64'(ir), 64'h0);
    chk("rst_irpc", ir_pc, 64'h0);
    chk("rst_valid", 64'(ir_valid), 64'd0);
    chk("rst_adv", 64'(pc_advance), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);

    // Zero-wait memory at pc=0, decode always ready
    reset = 1'b0; ir_ready = 1'b1;
    tick();
    chk("zw_req", 64'(mem_req), 64'd1);
    chk("zw_addr", mem_addr, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_0013;
    tick();
    chk("zw_ir", 64'(ir), 64'h1111_0013);
    chk("zw_irpc", ir_pc, 64'h0);
    chk("zw_valid", 64'(ir_valid), 64'd1);
    chk("zw_req_drop", 64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    tick();
    chk("zw_adv", 64'(pc_advance), 64'd1);
    chk("zw_valid_clr", 64'(ir_valid), 64'd0);
    pc = 64'h4;
    tick();
    chk("zw_adv_pulse", 64'(pc_advance), 64'd0);
    chk("zw_req2", 64'(mem_req), 64'd1);
    chk("zw_addr2", mem_addr, 64'h4);
    mem_ack = 1'b1; mem_rdata = 32'h2222_0093;
    tick();
    chk("zw_ir2", 64'(ir), 64'h2222_0093);
    chk("zw_irpc2", ir_pc, 64'h4);
    mem_ack = 1'b0;
    tick();
    chk("zw_adv2", 64'(pc_advance), 64'd1);
    pc = 64'h100;

    // Memory answers after 4 wait cycles at pc=0x100
    tick();
    chk("wt_req", 64'(mem_req), 64'd1);
    chk("wt_addr", mem_addr, 64'h100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wt_req_hold", 64'(mem_req), 64'd1);
      chk("wt_addr_hold", mem_addr, 64'h100);
      chk("wt_valid_lo", 64'(ir_valid), 64'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    chk("wt_valid", 64'(ir_valid), 64'd1);
    chk("wt_ir", 64'(ir), 64'hAAAA_5555);
    chk("wt_irpc", ir_pc, 64'h100);
    mem_ack = 1'b0;
    tick();
    chk("wt_adv", 64'(pc_advance), 64'd1);
    pc = 64'h200;

    // Flush into a 5-cycle read at 0x200, redirect to 0x400
    tick();
    chk("fl_addr", mem_addr, 64'h200);
    tick();
    flush = 1'b1; pc = 64'h400;
    tick();
    chk("fl_drop_req", 64'(mem_req), 64'd1);
    chk("fl_drop_addr", mem_addr, 64'h200);
    tick();
    chk("fl_reflush_addr", mem_addr, 64'h200);
    flush = 1'b0;
    tick();
    chk("fl_drop_req2", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("fl_req_clr", 64'(mem_req), 64'd0);
    chk("fl_valid", 64'(ir_valid), 64'd0);
    chk("fl_adv", 64'(pc_advance), 64'd0);
    mem_ack = 1'b0;
    tick();
    chk("fl_new_req", 64'(mem_req), 64'd1);
    chk("fl_new_addr", mem_addr, 64'h400);
    chk("fl_valid2", 64'(ir_valid), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0400;
    tick();
    chk("fl_irpc", ir_pc, 64'h400);
    mem_ack = 1'b0;
    tick();
    chk("fl_adv2", 64'(pc_advance), 64'd1);
    pc = 64'h40; ir_ready = 1'b0;

    // Decode stalls 6 cycles in HOLD at 0x40, then flush beats ready
    tick();
    chk("st_addr", mem_addr, 64'h40);
    mem_ack = 1'b1; mem_rdata = 32'h0123_4567;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("st_ir", 64'(ir), 64'h0123_4567);
      chk("st_irpc", ir_pc, 64'h40);
      chk("st_valid", 64'(ir_valid), 64'd1);
      chk("st_req", 64'(mem_req), 64'd0);
      chk("st_adv", 64'(pc_advance), 64'd0);
    end
    ir_ready = 1'b1; flush = 1'b1; pc = 64'h6;
    tick();
    chk("st_fl_valid", 64'(ir_valid), 64'd0);
    chk("st_fl_adv", 64'(pc_advance), 64'd0);
    flush = 1'b0; ir_ready = 1'b0;

    // Misaligned PC faults and parks until a flush
    tick();
    chk("ft_fault", 64'(fault), 64'd1);
    chk("ft_req", 64'(mem_req), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ft_sticky", 64'(fault), 64'd1);
      chk("ft_req_lo", 64'(mem_req), 64'd0);
      chk("ft_valid_lo", 64'(ir_valid), 64'd0);
    end
    flush = 1'b1; pc = 64'h8;
    tick();
    chk("ft_clr", 64'(fault), 64'd0);
    flush = 1'b0;
    tick();
    chk("ft_req8", 64'(mem_req), 64'd1);
    chk("ft_addr8", mem_addr, 64'h8);

    // Reset while a request is outstanding; a late ack must be ignored
    reset = 1'b1;
    tick();
    chk("rr_req", 64'(mem_req), 64'd0);
    chk("rr_addr", mem_addr, 64'h0);
    chk("rr_ir", 64'(ir), 64'h0);
    chk("rr_irpc", ir_pc, 64'h0);
    chk("rr_valid", 64'(ir_valid), 64'd0);
    chk("rr_fault", 64'(fault), 64'd0);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; pc = 64'h10;
    tick();
    chk("rr_late_valid", 64'(ir_valid), 64'd0);
    chk("rr_new_req", 64'(mem_req), 64'd1);
    chk("rr_new_addr", mem_addr, 64'h10);
    mem_ack = 1'b0;
    tick();
    chk("rr_late_valid2", 64'(ir_valid), 64'd0);
    chk("rr_ir_clean", 64'(ir), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
